// File: rtl/cpu0_fetch_if.sv
// Fetch-stage bundle: byte memory read port, instruction hand-off to decode, redirect input.
// master = fetch unit, slave = memory/decode/core side.
interface cpu0_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;

    modport master (
        output mem_req, mem_addr, ir, ir_pc, ir_valid,
        input  mem_ack, mem_rdata, ir_ready, redir_valid, redir_pc
    );

    modport slave (
        input  mem_req, mem_addr, ir, ir_pc, ir_valid,
        output mem_ack, mem_rdata, ir_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/cpu0_fetch.sv
// Generic word FIFO with synchronous flush; head is combinational from storage.
// Caller never pushes into a full FIFO unless it pops in the same cycle.
module cpu0_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
    assign count    = cnt;
endmodule

// Byte-serial instruction fetch: assembles big-endian words, queues them for decode.
// First word 5 edges after reset; decode stall stops new words once the FIFO fills.
module cpu0_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset_n,
    cpu0_fetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {FETCH, DISCARD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pending_pc_q, pending_pc_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   asm_q, asm_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          ack, hold, push, pop, flush, ir_valid;
    ent_t          push_ent, head_ent;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   redir_tgt;
    logic          unused_redir_lsbs;

    assign redir_tgt         = {bus.redir_pc[31:2], 2'b00};
    assign unused_redir_lsbs = ^bus.redir_pc[1:0];
    assign ack               = mem_req_q & bus.mem_ack;
    assign hold              = mem_req_q & ~bus.mem_ack;
    assign ir_valid          = (count != '0);
    assign pop               = ir_valid & bus.ir_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pending_pc_d  = pending_pc_q;
        byte_cnt_d    = byte_cnt_q;
        asm_d         = asm_q;
        push          = 1'b0;
        flush         = 1'b0;
        push_ent.pc   = fetch_pc_q;
        push_ent.word = {asm_q, bus.mem_rdata};

        case (state_q)
            FETCH: begin
                if (bus.redir_valid) begin
                    flush = 1'b1;
                    if (hold) begin
                        // The in-flight byte must still be accepted before refetching.
                        pending_pc_d = redir_tgt;
                        state_d      = DISCARD;
                    end else begin
                        fetch_pc_d = redir_tgt;
                        byte_cnt_d = 2'd0;
                    end
                end else if (ack) begin
                    if (byte_cnt_q == 2'd3) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        byte_cnt_d = 2'd0;
                    end else begin
                        asm_d      = {asm_q[15:0], bus.mem_rdata};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            DISCARD: begin
                if (bus.redir_valid) begin
                    flush        = 1'b1;
                    pending_pc_d = redir_tgt;
                end
                if (ack) begin
                    fetch_pc_d = bus.redir_valid ? redir_tgt : pending_pc_q;
                    byte_cnt_d = 2'd0;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);

        if (hold) begin
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q;
        end else begin
            // A started word always owns a slot; only byte 0 waits for space.
            mem_req_d  = (byte_cnt_d != 2'd0) || (count_nxt < CW'(DEPTH));
            mem_addr_d = fetch_pc_d + {30'd0, byte_cnt_d};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    cpu0_fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (count)
    );

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.ir       = head_ent.word;
    assign bus.ir_pc    = head_ent.pc;
    assign bus.ir_valid = ir_valid;
endmodule

// File: tb/tb_cpu0_fetch.sv
// Bench for cpu0_fetch: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based fetch model.
module tb_cpu0_fetch;
    localparam int DEPTH = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    cpu0_fetch_if bus();

    cpu0_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc_n    = 0;
    bit   chk_en   = 1'b0;
    int   ack_mode = 0;
    bit   rdy_rand = 1'b0;
    logic [7:0]  mem_bytes [256];
    logic [31:0] prog [4];

    // Reference model: address sequence and queue of completed (pc, word) entries.
    logic        m_req  = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_pend = '0;
    int          m_nb   = 0;
    bit          m_disc = 1'b0;
    logic [63:0] m_q[$];
    bit          m_hold, m_ack, m_pop;
    logic [31:0] m_tgt;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return mem_bytes[a[7:0]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a), byte_at(a + 32'd1), byte_at(a + 32'd2), byte_at(a + 32'd3)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_req = 1'b0; m_addr = '0; m_pc = '0; m_pend = '0; m_nb = 0; m_disc = 1'b0;
            m_q.delete();
        end else begin
            m_hold = m_req && !bus.mem_ack;
            m_ack  = m_req && bus.mem_ack;
            m_pop  = (m_q.size() != 0) && bus.ir_ready;
            m_tgt  = bus.redir_pc & ~32'd3;
            if (bus.redir_valid) begin
                m_q.delete();
                m_nb = 0;
                if (m_hold) begin m_disc = 1'b1; m_pend = m_tgt; end
                else begin m_disc = 1'b0; m_pc = m_tgt; end
            end else if (m_disc) begin
                if (m_ack) begin m_disc = 1'b0; m_pc = m_pend; m_nb = 0; end
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_ack) begin
                    m_nb++;
                    if (m_nb == 4) begin
                        m_q.push_back({m_pc, word_at(m_pc)});
                        m_pc = m_pc + 32'd4;
                        m_nb = 0;
                    end
                end
            end
            if (!m_hold) begin
                m_req  = (m_nb != 0) || (m_q.size() < DEPTH);
                m_addr = m_pc + 32'(m_nb);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("mem_req", 64'(bus.mem_req), 64'(m_req));
            chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
            chk("ir_valid", 64'(bus.ir_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("ir", 64'(bus.ir), 64'(m_q[0][31:0]));
                chk("ir_pc", 64'(bus.ir_pc), 64'(m_q[0][63:32]));
            end
            if (!reset_n) begin
                chk("rst_ir", 64'(bus.ir), 64'(0));
                chk("rst_ir_pc", 64'(bus.ir_pc), 64'(0));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
        cyc_n++;
        case (ack_mode)
            0:       bus.mem_ack = 1'b1;
            1:       bus.mem_ack = (cyc_n % 3 == 0);
            2:       bus.mem_ack = 1'($urandom_range(0, 1));
            default: bus.mem_ack = 1'b0;
        endcase
        if (rdy_rand) bus.ir_ready = 1'($urandom_range(0, 1));
        bus.redir_valid = 1'b0;
        bus.mem_rdata   = mem_bytes[bus.mem_addr[7:0]];
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n         = 1'b0;
        bus.redir_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int k = 0; k < max_cyc && !bus.ir_valid; k++) cyc();
    endtask

    initial begin
        prog[0] = 32'h001F0018; prog[1] = 32'h002F0010;
        prog[2] = 32'h003F0014; prog[3] = 32'h13221000;
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom_range(0, 255));
        for (int w = 0; w < 4; w++) begin
            mem_bytes[4*w]     = prog[w][31:24];
            mem_bytes[4*w + 1] = prog[w][23:16];
            mem_bytes[4*w + 2] = prog[w][15:8];
            mem_bytes[4*w + 3] = prog[w][7:0];
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = '0; bus.ir_ready = 1'b1;
        bus.redir_valid = 1'b0; bus.redir_pc = '0;

        #2 reset_n = 1'b0;
        #1;
        chk("reset_mem_req", 64'(bus.mem_req), 64'(0));
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("reset_ir_valid", 64'(bus.ir_valid), 64'(0));
        chk("reset_ir", 64'(bus.ir), 64'(0));
        chk("reset_ir_pc", 64'(bus.ir_pc), 64'(0));
        chk_en = 1'b1;
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Zero-wait stream of the four program words.
        cyc();
        chk("t1_first_req", 64'(bus.mem_req), 64'(1));
        chk("t1_first_addr", 64'(bus.mem_addr), 64'(0));
        repeat (3) cyc();
        chk("t1_valid_edge4", 64'(bus.ir_valid), 64'(0));
        cyc();
        chk("t1_valid_edge5", 64'(bus.ir_valid), 64'(1));
        for (int w = 0; w < 4; w++) begin
            wait_valid(8);
            chk("t1_ir", 64'(bus.ir), 64'(prog[w]));
            chk("t1_ir_pc", 64'(bus.ir_pc), 64'(4 * w));
            cyc();
            chk("t1_single_cycle", 64'(bus.ir_valid), 64'(0));
        end

        // Decode stalled: FIFO fills, fetch parks at 8, then resumes.
        bus.ir_ready = 1'b0;
        do_reset();
        repeat (12) cyc();
        chk("t2_req_drop", 64'(bus.mem_req), 64'(0));
        chk("t2_addr_park", 64'(bus.mem_addr), 64'(8));
        chk("t2_head_pc", 64'(bus.ir_pc), 64'(0));
        bus.ir_ready = 1'b1;
        cyc();
        chk("t2_head_pc_next", 64'(bus.ir_pc), 64'(4));
        chk("t2_resume_req", 64'(bus.mem_req), 64'(1));
        chk("t2_resume_addr", 64'(bus.mem_addr), 64'(8));
        repeat (6) cyc();

        // Slow memory.
        ack_mode = 1;
        do_reset();
        wait_valid(60);
        chk("t3_valid", 64'(bus.ir_valid), 64'(1));
        chk("t3_ir", 64'(bus.ir), 64'(32'h001F0018));
        chk("t3_ir_pc", 64'(bus.ir_pc), 64'(0));

        // Redirect to 0x0E at byte 2 with same-edge ack.
        ack_mode = 0;
        do_reset();
        repeat (3) cyc();
        chk("t4_addr_byte2", 64'(bus.mem_addr), 64'(2));
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_000E;
        cyc();
        chk("t4_addr_redir", 64'(bus.mem_addr), 64'(32'hC));
        chk("t4_no_valid", 64'(bus.ir_valid), 64'(0));
        wait_valid(10);
        chk("t4_ir", 64'(bus.ir), 64'(32'h13221000));
        chk("t4_ir_pc", 64'(bus.ir_pc), 64'(32'hC));

        // Two redirects while the request to 0x05 is stalled.
        do_reset();
        repeat (6) cyc();
        chk("t5_addr_stall", 64'(bus.mem_addr), 64'(5));
        ack_mode = 3; bus.mem_ack = 1'b0;
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_0010;
        cyc();
        chk("t5_hold_req", 64'(bus.mem_req), 64'(1));
        chk("t5_hold_addr", 64'(bus.mem_addr), 64'(5));
        chk("t5_flushed", 64'(bus.ir_valid), 64'(0));
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_000C;
        ack_mode = 0;
        cyc();
        chk("t5_still_addr", 64'(bus.mem_addr), 64'(5));
        cyc();
        chk("t5_restart_addr", 64'(bus.mem_addr), 64'(32'hC));
        chk("t5_no_stale", 64'(bus.ir_valid), 64'(0));
        wait_valid(10);
        chk("t5_ir", 64'(bus.ir), 64'(32'h13221000));
        chk("t5_ir_pc", 64'(bus.ir_pc), 64'(32'hC));

        // Reset mid-word with one entry queued.
        bus.ir_ready = 1'b0;
        do_reset();
        repeat (6) cyc();
        chk("t6_one_entry", 64'(bus.ir_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("t6_rst_req", 64'(bus.mem_req), 64'(0));
        chk("t6_rst_addr", 64'(bus.mem_addr), 64'(0));
        chk("t6_rst_valid", 64'(bus.ir_valid), 64'(0));
        chk("t6_rst_ir", 64'(bus.ir), 64'(0));
        @(posedge clock);
        #1 reset_n = 1'b1;
        bus.ir_ready = 1'b1;
        cyc();
        chk("t6_restart_req", 64'(bus.mem_req), 64'(1));
        chk("t6_restart_addr", 64'(bus.mem_addr), 64'(0));

        // Random traffic against the model.
        ack_mode = 2;
        rdy_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if ($urandom_range(0, 99) < 4) begin
                bus.redir_valid = 1'b1;
                if ($urandom_range(0, 7) == 0)
                    bus.redir_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else
                    bus.redir_pc = 32'($urandom_range(0, 255));
            end
            reset_n = ($urandom_range(0, 799) != 0);
        end
        reset_n = 1'b1;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu0_fetch.md
Name: cpu0_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the CPU0 execute core.
- Reads the byte-wide program memory one byte per transaction and assembles big-endian 32-bit instruction words: the byte at PC is IR[31:24].
- Buffers completed words in a small FIFO and hands each word plus its PC to decode over a valid/ready handshake.
- Accepts redirects (JMP target) from the core, which flush all fetched and partially fetched state.

Parameters:
DEPTH, 2, number of instruction-word FIFO entries (≥1).
RESET_PC, 32'h00000000, fetch address after reset.

Ports:
clock  input  1  single clock, rising-edge active.
reset_n  input  1  asynchronous, active-low reset.
mem_req  output  1  byte read request (registered).
mem_addr  output  32  byte address (registered).
mem_ack  input  1  read accepted; a transaction completes on an edge where mem_req && mem_ack. Same-cycle ack allowed.
mem_rdata  input  8  read byte, valid when mem_ack=1.
ir  output  32  instruction word at FIFO head.
ir_pc  output  32  byte address of ir.
ir_valid  output  1  FIFO non-empty.
ir_ready  input  1  decode accepts; pop on ir_valid && ir_ready.
redir_valid  input  1  redirect request, single-cycle pulse or held.
redir_pc  input  32  new fetch address; bits [1:0] ignored (forced to 0).

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous, active-low, on reset_n. While reset_n=0: mem_req=0, mem_addr=0, ir=0, ir_pc=0, ir_valid=0, FIFO empty, fetch_pc=RESET_PC, byte_cnt=0, state=FETCH. Reset asserted mid-transaction abandons it immediately.
- States:
  - FETCH: issuing or waiting on word bytes.
  - DISCARD: a redirect arrived while a request was outstanding.
- Memory protocol:
  - While mem_req=1 and no ack, mem_req and mem_addr are held stable.
  - mem_addr = fetch_pc + byte_cnt.
  - Accepted byte k (byte_cnt=k) goes to assembly bits [31-8k -: 8].
- Word start: byte 0 of a word is requested only if the FIFO count after this cycle's push/pop is < DEPTH. Once started, the word always has a free slot.
- Word completion: on acceptance of byte 3 the word is pushed with ir_pc=fetch_pc, fetch_pc += 4 (32-bit wrap from FFFFFFFC to 0), byte_cnt=0.
- Next request timing: the next request is driven on the same edge if the start rule allows, else mem_req=0.
- Throughput: with a zero-wait memory (mem_ack tied 1), mem_req stays high and mem_addr advances each cycle, giving 4 cycles per word.
- Reset latency: first mem_req=1 (addr=RESET_PC) after the first edge past reset release. First word is in the FIFO (ir_valid=1) after the 5th edge.
- Push and pop in the same cycle are allowed at any count.
- FIFO full: no new word starts. An in-progress word still completes.
- FIFO empty: ir_valid=0; ir/ir_pc hold their last values (don't-care).
- Redirect, no outstanding request (mem_req=0, or ack on this edge): FIFO flushed, partial word dropped, fetch_pc=redir_pc&~3, byte_cnt=0. The request for redir_pc byte 0 is issued on the same edge.
- Redirect while mem_req=1 && !mem_ack:
  - FIFO flushed, partial word dropped, pending_pc latched, go to DISCARD.
  - In DISCARD, mem_req/mem_addr stay stable until ack. The acked byte is discarded and fetch restarts at pending_pc.
- Redirect during DISCARD: pending_pc updated; latest wins.
- Redirect with a pop in the same cycle: redirect wins; the pop is a no-op because the entry is flushed.
- Redirect and byte-3 ack on the same edge: the word is not pushed.
- ir_valid=0 on the edge after any redirect.

Test Plan:
- Zero-wait memory holding 001F0018, 002F0010, 003F0014, 13221000 at 0x0..0xF, ir_ready=1 → ir sequence 001F0018@0, 002F0010@4, 003F0014@8, 13221000@C. Each ir_valid=1 exactly one cycle. mem_addr advances 0,1,2,…
- ir_ready=0, DEPTH=2 → after 2 words mem_req drops with mem_addr=8. Raise ir_ready → words @0 and @4 pop, then fetch resumes at 8. No word is lost or duplicated.
- Memory acks every 3rd cycle → mem_addr/mem_req stable while waiting. Word 001F0018 is assembled correctly.
- Redirect to 0x0000000E mid-word (byte_cnt=2, ack same cycle) → partial word dropped, next mem_addr=0x0C, next ir_pc=0x0C, ir=13221000.
- Redirect to 0x10 while a request to 0x05 is stalled, then a second redirect to 0x0C before the ack → byte from 0x05 discarded, fetch resumes at 0x0C, no stale ir_valid.
- Assert reset_n=0 mid-word with the FIFO holding 1 entry → outputs go to reset values immediately. After release, fetch restarts at RESET_PC.
